// File: rtl/fpu_op_scheduler_pkg.sv
// Shared FPU definitions: opcode encoding, datapath widths and
// the operation scheduler state encoding.
package fpu_op_scheduler_pkg;

    localparam int FPU_OPW   = 5;
    localparam int FPU_DESCW = 32;

    typedef enum logic [FPU_OPW-1:0] {
        FOP_ADD   = 5'h00,
        FOP_SUB   = 5'h01,
        FOP_MUL   = 5'h02,
        FOP_DIV   = 5'h03,
        FOP_SQRT  = 5'h04,
        FOP_FMADD = 5'h05,
        FOP_FMSUB = 5'h06,
        FOP_MIN   = 5'h07,
        FOP_MAX   = 5'h08,
        FOP_CMP   = 5'h09,
        FOP_CVTIF = 5'h0a,
        FOP_CVTFI = 5'h0b,
        FOP_SGNJ  = 5'h0c,
        FOP_CLASS = 5'h0d
    } fpu_op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_BUSY  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } sched_state_t;

    function automatic int rr_wrap(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fpu_op_scheduler_if.sv
// Requester and datapath bundle of the FPU operation scheduler.
// master = requesters/datapath side, slave = scheduler side.
interface fpu_op_scheduler_if
    import fpu_op_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0][FPU_OPW-1:0]   req_opcode;
    logic [NUM_REQ-1:0][FPU_DESCW-1:0] req_desc;
    logic [NUM_REQ-1:0]                req_ack;
    logic [NUM_REQ-1:0]                resp_valid;
    logic                              resp_err;
    logic                              fpu_go;
    logic [FPU_OPW-1:0]                fpu_opcode;
    logic [FPU_DESCW-1:0]              fpu_desc;
    logic                              fpu_done;
    logic                              busy;

    modport master (
        output req_valid,
        output req_opcode,
        output req_desc,
        output fpu_done,
        input  req_ack,
        input  resp_valid,
        input  resp_err,
        input  fpu_go,
        input  fpu_opcode,
        input  fpu_desc,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_opcode,
        input  req_desc,
        input  fpu_done,
        output req_ack,
        output resp_valid,
        output resp_err,
        output fpu_go,
        output fpu_opcode,
        output fpu_desc,
        output busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request found
// searching upward from ptr with wrap.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    int idx;

    // Walk from the farthest slot back to ptr so the nearest request wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (((req >> idx) & ONE) != '0) begin
                grant = ONE << idx;
            end
        end
    end

endmodule

// File: rtl/fpu_op_scheduler.sv
// Shares one FPU datapath among NUM_REQ requesters: round-robin
// grant, go/done handshake, watchdog abort and stale-done drain.
module fpu_op_scheduler
    import fpu_op_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input logic               clk,
    input logic               rst,
    fpu_op_scheduler_if.slave bus
);

    localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_MAX  = '1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    sched_state_t         state, state_nx;
    logic [PW-1:0]        ptr, ptr_nx;
    logic [PW-1:0]        win, win_nx;
    logic [WDW-1:0]       wd, wd_nx;
    logic                 tmo, tmo_nx;
    logic                 err, err_nx;
    fpu_op_t              op, op_nx;
    logic [FPU_DESCW-1:0] desc, desc_nx;
    logic [NUM_REQ-1:0]   ack, ack_nx;
    logic [NUM_REQ-1:0]   rsp, rsp_nx;
    logic                 rsp_err, rsp_err_nx;
    logic                 go, go_nx;
    logic                 bsy, bsy_nx;
    logic [NUM_REQ-1:0]   grant;
    logic [PW-1:0]        gidx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        gidx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                gidx = PW'(k);
            end
        end
    end

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        win_nx     = win;
        wd_nx      = wd;
        tmo_nx     = tmo;
        err_nx     = err;
        op_nx      = op;
        desc_nx    = desc;
        ack_nx     = '0;
        rsp_nx     = '0;
        rsp_err_nx = 1'b0;
        go_nx      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    ack_nx   = grant;
                    win_nx   = gidx;
                    op_nx    = fpu_op_t'(bus.req_opcode[gidx]);
                    desc_nx  = bus.req_desc[gidx];
                    ptr_nx   = PW'(rr_wrap(int'(gidx), NUM_REQ));
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                go_nx    = 1'b1;
                wd_nx    = '0;
                tmo_nx   = 1'b0;
                state_nx = S_BUSY;
            end
            S_BUSY: begin
                if (wd != WD_MAX) begin
                    wd_nx = wd + WDW'(1);
                end
                // Limit compare is registered so it stays off the done path.
                tmo_nx = (wd == WD_LAST);
                if (bus.fpu_done) begin
                    err_nx     = 1'b0;
                    rsp_nx     = ONE << win;
                    rsp_err_nx = 1'b0;
                    state_nx   = S_RESP;
                end else if (tmo) begin
                    err_nx     = 1'b1;
                    rsp_nx     = ONE << win;
                    rsp_err_nx = 1'b1;
                    state_nx   = S_RESP;
                end
            end
            S_RESP: begin
                state_nx = bus.fpu_done ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (!bus.fpu_done) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        bsy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            win     <= '0;
            wd      <= '0;
            tmo     <= 1'b0;
            err     <= 1'b0;
            op      <= FOP_ADD;
            desc    <= '0;
            ack     <= '0;
            rsp     <= '0;
            rsp_err <= 1'b0;
            go      <= 1'b0;
            bsy     <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            win     <= win_nx;
            wd      <= wd_nx;
            tmo     <= tmo_nx;
            err     <= err_nx;
            op      <= op_nx;
            desc    <= desc_nx;
            ack     <= ack_nx;
            rsp     <= rsp_nx;
            rsp_err <= rsp_err_nx;
            go      <= go_nx;
            bsy     <= bsy_nx;
        end
    end

    assign bus.req_ack    = ack;
    assign bus.resp_valid = rsp;
    assign bus.resp_err   = rsp_err;
    assign bus.fpu_go     = go;
    assign bus.fpu_opcode = op;
    assign bus.fpu_desc   = desc;
    assign bus.busy       = bsy;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Scoreboard bench for fpu_op_scheduler: expected grants queued by
// stimulus, checked by a monitor on every ack/go/resp.
module tb_fpu_op_scheduler;
    import fpu_op_scheduler_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 16;

    typedef struct {
        int          idx;
        logic [4:0]  op;
        logic [31:0] desc;
        int          lat;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_op_scheduler_if #(.NUM_REQ(N)) bus ();

    fpu_op_scheduler #(
        .NUM_REQ (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t expq[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ack_cnt = 0;
    int   resp_cnt = 0;
    int   go_cnt = 0;
    int   ack_cyc = 0;
    int   go_cyc = 0;
    bit   pend = 1'b0;
    int   dp_delay = 3;
    int   dp_hold = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int idx, input logic [4:0] op,
                                input logic [31:0] desc, input int lat,
                                input bit err);
        exp_t e;
        e.idx  = idx;
        e.op   = op;
        e.desc = desc;
        e.lat  = lat;
        e.err  = err;
        return e;
    endfunction

    // Datapath model: done rises dp_delay cycles after go, held dp_hold.
    initial begin
        bus.fpu_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.fpu_go && !rst && dp_delay >= 0) begin
                repeat (dp_delay) @(negedge clk);
                bus.fpu_done = 1'b1;
                repeat (dp_hold) @(negedge clk);
                bus.fpu_done = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (bus.req_ack != '0) begin
                    ack_cnt++;
                    ack_cyc = cyc;
                    if (expq.size() == 0) begin
                        check("ack_unexpected", 64'(bus.req_ack), 64'd0);
                    end else begin
                        cur = expq.pop_front();
                        check("ack_idx", 64'(bus.req_ack), 64'(N'(1) << cur.idx));
                        pend = 1'b1;
                    end
                end
                if (bus.fpu_go) begin
                    go_cnt++;
                    go_cyc = cyc;
                    check("go_lat", 64'(cyc - ack_cyc), 64'd1);
                    check("go_op", 64'(bus.fpu_opcode), 64'(cur.op));
                    check("go_desc", 64'(bus.fpu_desc), 64'(cur.desc));
                    check("go_done_low", 64'(bus.fpu_done), 64'd0);
                end
                if (bus.resp_valid != '0) begin
                    resp_cnt++;
                    check("resp_pending", 64'(pend), 64'd1);
                    check("resp_idx", 64'(bus.resp_valid), 64'(N'(1) << cur.idx));
                    check("resp_err", 64'(bus.resp_err), 64'(cur.err));
                    check("resp_lat", 64'(cyc - go_cyc), 64'(cur.lat));
                    check("op_stable", 64'(bus.fpu_opcode), 64'(cur.op));
                    check("desc_stable", 64'(bus.fpu_desc), 64'(cur.desc));
                    pend = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input int target, input int budget, input string name);
        int t = 0;
        while (ack_cnt < target && t < budget) begin
            tick();
            t++;
        end
        check(name, 64'(ack_cnt >= target), 64'd1);
    endtask

    task automatic wait_resp(input int target, input int budget, input string name);
        int t = 0;
        while (resp_cnt < target && t < budget) begin
            tick();
            t++;
        end
        check(name, 64'(resp_cnt >= target), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"}, 64'(bus.req_ack), 64'd0);
        check({tag, "_resp"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_err"}, 64'(bus.resp_err), 64'd0);
        check({tag, "_go"}, 64'(bus.fpu_go), 64'd0);
        check({tag, "_op"}, 64'(bus.fpu_opcode), 64'd0);
        check({tag, "_desc"}, 64'(bus.fpu_desc), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    // Single requester, FSM idle: ack exactly one cycle after raise.
    task automatic one_op(input int idx, input logic [4:0] op,
                          input logic [31:0] desc, input int lat,
                          input bit err, input string tag);
        int a0 = ack_cnt;
        int r0 = resp_cnt;
        int c0 = cyc;
        expq.push_back(mk(idx, op, desc, lat, err));
        bus.req_opcode[idx] = op;
        bus.req_desc[idx]   = desc;
        bus.req_valid[idx]  = 1'b1;
        wait_ack(a0 + 1, 20, {tag, "_ack_wait"});
        check({tag, "_ack_cyc"}, 64'(ack_cyc - c0), 64'd1);
        bus.req_valid[idx] = 1'b0;
        wait_resp(r0 + 1, 80, {tag, "_resp_wait"});
    endtask

    initial begin
        int r0;
        int a0;
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_opcode = '0;
        bus.req_desc   = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // All four held valid: grants 0,1,2,3 then wrap to 0.
        dp_delay = 3;
        dp_hold  = 1;
        for (int i = 0; i < N; i++) begin
            bus.req_opcode[i] = 5'(16 + i);
            bus.req_desc[i]   = 32'hA000_0000 + 32'(i);
            expq.push_back(mk(i, 5'(16 + i), 32'hA000_0000 + 32'(i), 4, 1'b0));
        end
        expq.push_back(mk(0, 5'd16, 32'hA000_0000, 4, 1'b0));
        bus.req_valid = 4'b1111;
        wait_ack(5, 120, "rr_ack_wait");
        bus.req_valid = '0;
        wait_resp(5, 40, "rr_resp_wait");
        check("rr_queue_empty", 64'(expq.size()), 64'd0);
        repeat (3) tick();

        // Single request, done 10 cycles after go.
        dp_delay = 10;
        one_op(2, 5'h03, 32'h0000_1000, 11, 1'b0, "single");
        repeat (3) tick();

        // Timeout: done never arrives.
        dp_delay = -1;
        one_op(1, 5'h04, 32'h0000_2000, 17, 1'b1, "timeout");
        tick();
        check("timeout_idle_busy", 64'(bus.busy), 64'd0);
        repeat (3) tick();

        // Done lands on the timeout cycle: done wins.
        dp_delay = 16;
        one_op(3, 5'h02, 32'h0000_3000, 17, 1'b0, "coincide");
        repeat (3) tick();

        // Long done with a second requester waiting: drain before next go.
        dp_delay = 2;
        dp_hold  = 5;
        r0 = resp_cnt;
        a0 = ack_cnt;
        bus.req_opcode[1] = 5'h05;
        bus.req_desc[1]   = 32'h0000_4001;
        bus.req_opcode[3] = 5'h06;
        bus.req_desc[3]   = 32'h0000_4003;
        expq.push_back(mk(1, 5'h05, 32'h0000_4001, 3, 1'b0));
        expq.push_back(mk(3, 5'h06, 32'h0000_4003, 3, 1'b0));
        bus.req_valid = 4'b1010;
        wait_ack(a0 + 1, 20, "drain_ack1_wait");
        bus.req_valid[1] = 1'b0;
        wait_resp(r0 + 1, 40, "drain_resp1_wait");
        tick();
        check("drain_busy", 64'(bus.busy), 64'd1);
        check("drain_done_high", 64'(bus.fpu_done), 64'd1);
        check("drain_no_resp", 64'(bus.resp_valid), 64'd0);
        wait_ack(a0 + 2, 40, "drain_ack2_wait");
        bus.req_valid[3] = 1'b0;
        wait_resp(r0 + 2, 40, "drain_resp2_wait");
        repeat (8) tick();
        check("drain_resp_count", 64'(resp_cnt - r0), 64'd2);

        // Reset while BUSY: silent abort and pointer back to 0.
        dp_delay = -1;
        dp_hold  = 1;
        a0 = ack_cnt;
        r0 = go_cnt;
        expq.push_back(mk(2, 5'h07, 32'h0000_5000, 17, 1'b1));
        bus.req_opcode[2] = 5'h07;
        bus.req_desc[2]   = 32'h0000_5000;
        bus.req_valid[2]  = 1'b1;
        wait_ack(a0 + 1, 20, "rst_ack_wait");
        bus.req_valid[2] = 1'b0;
        repeat (4) tick();
        check("rst_go_seen", 64'(go_cnt - r0), 64'd1);
        r0 = resp_cnt;
        rst = 1'b1;
        tick();
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        repeat (20) tick();
        check("mid_reset_no_resp", 64'(resp_cnt), 64'(r0));
        check("mid_reset_idle", 64'(bus.busy), 64'd0);

        dp_delay = 3;
        a0 = ack_cnt;
        bus.req_opcode[0] = 5'h08;
        bus.req_desc[0]   = 32'h0000_6000;
        bus.req_opcode[3] = 5'h09;
        bus.req_desc[3]   = 32'h0000_6003;
        expq.push_back(mk(0, 5'h08, 32'h0000_6000, 4, 1'b0));
        expq.push_back(mk(3, 5'h09, 32'h0000_6003, 4, 1'b0));
        bus.req_valid = 4'b1001;
        wait_ack(a0 + 1, 20, "post_rst_ack1_wait");
        bus.req_valid[0] = 1'b0;
        wait_ack(a0 + 2, 40, "post_rst_ack2_wait");
        bus.req_valid[3] = 1'b0;
        wait_resp(r0 + 2, 40, "post_rst_resp_wait");
        repeat (5) tick();
        check("final_queue_empty", 64'(expq.size()), 64'd0);
        check("final_idle", 64'(bus.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_op_scheduler.md
FPU_OP_SCHEDULER -- requirements
Module: fpu_op_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the FPU datapath.
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles from go to done before abort.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request; held until req_ack.
REQ-006 req_opcode  input  NUM_REQ x 5  per-requester FPU opcode (fpu_op_t).
REQ-007 req_desc  input  NUM_REQ x 32  per-requester operand descriptor pointer.
REQ-008 req_ack  output  NUM_REQ  one-hot, 1-cycle pulse; request accepted.
REQ-009 resp_valid  output  NUM_REQ  one-hot, 1-cycle pulse; accepted operation finished.
REQ-010 resp_err  output  1  qualifies resp_valid; 1 = timeout abort.
REQ-011 fpu_go  output  1  1-cycle start pulse to datapath.
REQ-012 fpu_opcode  output  5  opcode to datapath; stable from go through done.
REQ-013 fpu_desc  output  32  descriptor to datapath; stable from go through done.
REQ-014 fpu_done  input  1  datapath completion level; sampled only in BUSY.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, BUSY, RESP, DRAIN.
REQ-017 IDLE: if any req_valid, select winner by round-robin, pulse req_ack[winner], latch opcode/desc/winner, go to ISSUE; else stay.
REQ-018 Round-robin: search starts at index ptr, where ptr resets to 0; after a grant, ptr = (winner+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
REQ-019 ISSUE: assert fpu_go for exactly one cycle, clear the watchdog counter, go to BUSY.
REQ-020 BUSY: increment the watchdog each cycle; fpu_done=1 -> RESP with error=0; watchdog reaching TIMEOUT-1 without done -> RESP with error=1.
REQ-021 If fpu_done and the timeout occur in the same cycle, done SHALL win (error=0).
REQ-022 RESP: pulse resp_valid[winner] with resp_err=error for one cycle; if fpu_done is still high, go to DRAIN; otherwise go to IDLE.
REQ-023 DRAIN: wait for fpu_done=0, then go to IDLE; this prevents a stale done being accepted for the next operation.
REQ-024 Latency: an ack in cycle N gives fpu_go in N+1; done sampled in cycle M gives resp_valid in M+1.
REQ-025 Minimum arbitration gap: the next req_ack comes no earlier than one cycle after resp_valid.
REQ-026 Requests deasserted before ack are dropped silently; req_valid is ignored outside IDLE.
REQ-027 The watchdog is $clog2(TIMEOUT)+1 bits and saturates and does not wrap.
REQ-028 Outputs are registered; there is no combinational path from req_valid or fpu_done to any output.

Reset
REQ-029 When rst is high at a clock edge: state=IDLE, ptr=0, watchdog=0, latched opcode/desc/winner=0, error=0.
REQ-030 All outputs are 0 during and after reset until the first grant.
REQ-031 Reset mid-operation (ISSUE/BUSY/RESP/DRAIN) aborts without emitting resp_valid; the datapath is not signalled.

Structure
REQ-032 fpu_op_t (5-bit opcode enum) and the scheduler state enum belong in the shared FPU package alongside the fpu_defines constants.
REQ-033 The round-robin arbiter is a sub-module rr_arbiter: inputs req, ptr; output one-hot grant; parameterised by NUM_REQ.
REQ-034 The FSM, watchdog and operand latches live in fpu_op_scheduler itself.

Verification
REQ-035 Single request: req_valid=4'b0100, op 5'h03, desc 0x1000, done 10 cycles after go -> ack[2] in cycle 1, go in cycle 2 with op 03 and desc 0x1000, resp_valid[2] with err=0.
REQ-036 All four requesters held valid -> grant order 0,1,2,3,0, each done 3 cycles after go; ptr wraps from 3 to 0.
REQ-037 TIMEOUT=16, done never asserted -> resp_valid with resp_err=1 exactly 17 cycles after fpu_go, then return to IDLE.
REQ-038 Done held high for 5 cycles -> a single resp_valid, the FSM stays in DRAIN until done falls, and the next fpu_go follows only after done=0.
REQ-039 rst asserted in BUSY -> no resp_valid, busy=0 and all outputs 0 next cycle, and the next grant goes to requester 0.
REQ-040 Done coinciding with the timeout cycle -> resp_err=0.
